// File: rtl/cpu_registerfile.sv
// Moxie general register file with per-register pending-write scoreboard.
// Two registered read ports with write-first bypass; combinational busy flags for RAW hazard detection.
module cpu_registerfile #(
  parameter int NREGS = 16,
  parameter int PENDW = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic [$clog2(NREGS)-1:0]   reg_index1_i,
  input  logic [$clog2(NREGS)-1:0]   reg_index2_i,
  output logic [31:0]                value1_o,
  output logic [31:0]                value2_o,
  input  logic                       write_enable_i,
  input  logic [$clog2(NREGS)-1:0]   write_index_i,
  input  logic [31:0]                write_value_i,
  input  logic                       reserve_i,
  input  logic [$clog2(NREGS)-1:0]   reserve_index_i,
  output logic                       busy1_o,
  output logic                       busy2_o,
  output logic                       overflow_o
);

  localparam int IW = $clog2(NREGS);

  logic [31:0]      regs [NREGS];
  logic [PENDW-1:0] pend [NREGS];
  logic [NREGS-1:0] inc_v;
  logic [NREGS-1:0] dec_v;
  logic             dec1;
  logic             dec2;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      inc_v[i] = reserve_i && (reserve_index_i == IW'(i));
      dec_v[i] = write_enable_i && (write_index_i == IW'(i)) && (pend[i] != '0);
    end
  end

  // A write retiring this cycle clears busy; its data reaches the reader via the bypass.
  always_comb begin
    dec1    = write_enable_i && (write_index_i == reg_index1_i) && (pend[reg_index1_i] != '0);
    dec2    = write_enable_i && (write_index_i == reg_index2_i) && (pend[reg_index2_i] != '0);
    busy1_o = (pend[reg_index1_i] - PENDW'(dec1)) != '0;
    busy2_o = (pend[reg_index2_i] - PENDW'(dec2)) != '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      value1_o   <= '0;
      value2_o   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (write_enable_i)
        regs[write_index_i] <= write_value_i;

      if (!stall_i) begin
        value1_o <= (write_enable_i && write_index_i == reg_index1_i) ? write_value_i
                                                                        : regs[reg_index1_i];
        value2_o <= (write_enable_i && write_index_i == reg_index2_i) ? write_value_i
                                                                        : regs[reg_index2_i];
      end

      for (int unsigned i = 0; i < NREGS; i++) begin
        if (inc_v[i] && !dec_v[i]) begin
          if (pend[i] == '1)
            overflow_o <= 1'b1;
          else
            pend[i] <= pend[i] + PENDW'(1);
        end else if (dec_v[i] && !inc_v[i]) begin
          pend[i] <= pend[i] - PENDW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_registerfile.sv
// Scoreboard bench for cpu_registerfile: directed stimulus queues expectations, a negedge monitor retires them.
module tb_cpu_registerfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic [3:0]  reg_index1_i;
  logic [3:0]  reg_index2_i;
  logic [31:0] value1_o;
  logic [31:0] value2_o;
  logic        write_enable_i;
  logic [3:0]  write_index_i;
  logic [31:0] write_value_i;
  logic        reserve_i;
  logic [3:0]  reserve_index_i;
  logic        busy1_o;
  logic        busy2_o;
  logic        overflow_o;

  cpu_registerfile #(.NREGS(16), .PENDW(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .reg_index1_i(reg_index1_i), .reg_index2_i(reg_index2_i),
    .value1_o(value1_o), .value2_o(value2_o),
    .write_enable_i(write_enable_i), .write_index_i(write_index_i),
    .write_value_i(write_value_i),
    .reserve_i(reserve_i), .reserve_index_i(reserve_index_i),
    .busy1_o(busy1_o), .busy2_o(busy2_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int K_V1 = 0, K_V2 = 1, K_B1 = 2, K_B2 = 3, K_OV = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] got;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_V1:    return value1_o;
      K_V2:    return value2_o;
      K_B1:    return {31'd0, busy1_o};
      K_B2:    return {31'd0, busy2_o};
      default: return {31'd0, overflow_o};
    endcase
  endfunction

  always @(negedge clk_i) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due == cyc) begin
        got = actual(sb[k].kind);
        checks++;
        if (got !== sb[k].exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sb[k].name, got, sb[k].exp, cyc);
        end
        sb.delete(k);
      end
    end
  end

  // delay 0: combinational output this cycle; delay 1: registered output after the next edge
  task automatic expect_at(input int kind, input logic [31:0] exp, input int delay, input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.due = cyc + delay; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    rst_i          = 1'b0;
    write_enable_i = 1'b0;
    reserve_i      = 1'b0;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] val);
    write_enable_i = 1'b1; write_index_i = idx; write_value_i = val;
  endtask

  task automatic rsv(input logic [3:0] idx);
    reserve_i = 1'b1; reserve_index_i = idx;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d expectations pending", sb.size());
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; stall_i = 1'b0;
    reg_index1_i = '0; reg_index2_i = '0;
    write_enable_i = 1'b0; write_index_i = '0; write_value_i = '0;
    reserve_i = 1'b0; reserve_index_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    tick();

    // reset state
    reg_index1_i = 4'd3; reg_index2_i = 4'd7;
    expect_at(K_B1, 0, 0, "reset_busy1");
    expect_at(K_B2, 0, 0, "reset_busy2");
    expect_at(K_OV, 0, 0, "reset_overflow");
    expect_at(K_V1, 0, 1, "reset_value1");
    expect_at(K_V2, 0, 1, "reset_value2");
    tick();

    // write then read back
    wr(4'd5, 32'hDEADBEEF); reg_index1_i = 4'd0;
    tick();
    reg_index1_i = 4'd5;
    write_index_i = 4'd5; write_value_i = 32'h0; // enable low: must not disturb regs[5]
    expect_at(K_V1, 32'hDEADBEEF, 1, "readback_5");
    tick();
    expect_at(K_V1, 32'hDEADBEEF, 1, "no_write_when_disabled");
    tick();

    // write-first bypass on both ports
    wr(4'd2, 32'h12345678); reg_index1_i = 4'd2; reg_index2_i = 4'd2;
    expect_at(K_V1, 32'h12345678, 1, "bypass_v1");
    expect_at(K_V2, 32'h12345678, 1, "bypass_v2");
    tick();
    reg_index1_i = 4'd7;
    expect_at(K_V2, 32'h12345678, 1, "stored_2");
    tick();

    // scoreboard on idx 4
    rsv(4'd4); reg_index1_i = 4'd4;
    expect_at(K_B1, 0, 0, "same_cycle_reserve_not_busy");
    tick();
    rsv(4'd4);
    expect_at(K_B1, 1, 0, "busy_pend1");
    tick();
    wr(4'd4, 32'hA);
    expect_at(K_B1, 1, 0, "busy_first_write_pend2");
    tick();
    wr(4'd4, 32'hB);
    expect_at(K_B1, 0, 0, "busy_clears_on_last_write");
    expect_at(K_V1, 32'hB, 1, "bypass_retire_value");
    tick();
    rsv(4'd4);
    tick();
    rsv(4'd4); wr(4'd4, 32'hC);
    expect_at(K_B1, 0, 0, "busy_reserve_plus_write");
    tick();
    expect_at(K_B1, 1, 0, "pend_unchanged_after_inc_dec");
    tick();
    wr(4'd4, 32'hD);
    tick();
    expect_at(K_B1, 0, 0, "idx4_idle");
    expect_at(K_OV, 0, 0, "no_overflow_yet");
    tick();

    // saturation on idx 9
    reg_index2_i = 4'd9;
    rsv(4'd9); tick();
    rsv(4'd9); tick();
    rsv(4'd9); tick();
    rsv(4'd9);
    expect_at(K_B2, 1, 0, "busy_saturated");
    expect_at(K_OV, 0, 0, "overflow_before_4th");
    expect_at(K_OV, 1, 1, "overflow_after_4th");
    tick();
    wr(4'd9, 32'h1); expect_at(K_B2, 1, 0, "sat_write1"); tick();
    wr(4'd9, 32'h2); expect_at(K_B2, 1, 0, "sat_write2"); tick();
    wr(4'd9, 32'h3); expect_at(K_B2, 0, 0, "sat_write3"); tick();
    wr(4'd9, 32'h99);
    expect_at(K_B2, 0, 0, "write_pend0_busy");
    expect_at(K_V2, 32'h99, 1, "write_pend0_bypass");
    tick();
    expect_at(K_B2, 0, 0, "no_underflow");
    expect_at(K_V2, 32'h99, 1, "write_pend0_stored");
    expect_at(K_OV, 1, 0, "overflow_sticky");
    tick();

    // stall holds read data; writes still land
    wr(4'd6, 32'h55); reg_index1_i = 4'd0;
    expect_at(K_V1, 0, 1, "pre_stall_value");
    tick();
    stall_i = 1'b1; reg_index1_i = 4'd6;
    expect_at(K_V1, 0, 1, "stall_hold1");
    tick();
    wr(4'd7, 32'h77);
    expect_at(K_V1, 0, 1, "stall_hold2");
    tick();
    stall_i = 1'b0;
    expect_at(K_V1, 32'h55, 1, "after_stall");
    tick();
    reg_index1_i = 4'd7;
    expect_at(K_V1, 32'h77, 1, "write_during_stall");
    tick();

    // reset mid-operation
    rsv(4'd1); tick();
    rsv(4'd1); tick();
    reg_index1_i = 4'd1; reg_index2_i = 4'd5;
    expect_at(K_B1, 1, 0, "pend1_before_reset");
    expect_at(K_V2, 32'hDEADBEEF, 1, "v2_before_reset");
    tick();
    rst_i = 1'b1;
    expect_at(K_V1, 0, 1, "reset_mid_v1");
    expect_at(K_V2, 0, 1, "reset_mid_v2");
    expect_at(K_OV, 0, 1, "reset_mid_overflow");
    tick();
    expect_at(K_B1, 0, 0, "reset_mid_busy1");
    expect_at(K_B2, 0, 0, "reset_mid_busy2");
    expect_at(K_V2, 0, 1, "reset_clears_regs");
    tick();
    tick();
    tick();

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations never checked, required 0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_registerfile.md
Name: cpu_registerfile

Overview:
- Moxie general register file and write-scoreboard: the consumer end of the execute stage's register write port (index/enable/result).
- Holds 16 x 32-bit registers ($fp, $sp, $r0-$r13).
- Provides two registered read ports feeding regA/regB of the execute stage.
- Tracks in-flight destination writes per register, so decode can detect RAW hazards and stall.

Parameters:
- NREGS, 16, number of architectural registers; index width is log2(NREGS)=4.
- PENDW, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^PENDW-1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- stall_i  in  1  pipeline stall; freezes read-data outputs
- reg_index1_i  in  4  read port A index
- reg_index2_i  in  4  read port B index
- value1_o  out  32  read port A data, registered
- value2_o  out  32  read port B data, registered
- write_enable_i  in  1  register write strobe from execute
- write_index_i  in  4  register write index from execute
- write_value_i  in  32  register write data from execute (result)
- reserve_i  in  1  decode issues an instruction that will write reserve_index_i
- reserve_index_i  in  4  destination being reserved
- busy1_o  out  1  reg_index1_i has an outstanding write (combinational)
- busy2_o  out  1  reg_index2_i has an outstanding write (combinational)
- overflow_o  out  1  sticky: reserve attempted on a saturated counter

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high, sampled on posedge clk_i.
- Reset state: all 16 registers = 0; all pending counters = 0; value1_o = value2_o = 0; overflow_o = 0.
- Reset mid-operation: wins over everything that cycle; in-flight reservations are discarded.
- Write: on posedge with write_enable_i=1, regs[write_index_i] <= write_value_i.
  - A write with write_enable_i=0 has no effect, regardless of index/value.
- Read latency is 1 cycle when stall_i=0:
  - value1_o <= regs[reg_index1_i]; value2_o <= regs[reg_index2_i].
- Write-first bypass: if write_enable_i=1 and write_index_i equals a read index in the same cycle, that read output gets write_value_i, not the stale entry.
  - Applies to both ports independently.
- stall_i=1: value1_o/value2_o hold. Writes and counter updates still occur.
- Pending counter pend[i], PENDW bits, unsigned. Per cycle, for each i:
  - inc = reserve_i && reserve_index_i==i
  - dec = write_enable_i && write_index_i==i && pend[i]!=0
  - inc && dec: pend unchanged.
  - inc only: pend+1, unless pend==max; then pend holds and overflow_o <= 1.
  - dec only: pend-1.
  - Write to a register with pend==0: the data is written and the counter stays 0 (no underflow).
- busy outputs (combinational): busy1_o = (pend[reg_index1_i] - dec_same_cycle) != 0, where dec_same_cycle = 1 if a write to that index retires this cycle.
  - A value completing this cycle is therefore not busy; it is delivered through the bypass.
  - Same rule for busy2_o.
  - A same-cycle reserve does not affect busy (it counts from the next cycle).
- overflow_o is cleared only by reset.
- All arithmetic is modulo 2^32; no sign handling. The block is storage only.

Test Plan:
- Reset then read idx 3 and 7 -> next cycle value1_o=0, value2_o=0, busy1_o=busy2_o=0, overflow_o=0.
- Write idx 5 = 0xDEADBEEF, later read idx 5 on port A -> value1_o=0xDEADBEEF 1 cycle after the index is presented.
- Same-cycle bypass: write idx 2 = 0x12345678 while both ports read idx 2 -> next cycle value1_o=value2_o=0x12345678.
- Scoreboard sequence on idx 4:
  - reserve 4 twice -> busy1_o=1 with reg_index1_i=4.
  - First write to 4 -> busy1_o stays 1.
  - Second write -> busy1_o=0 in that same cycle.
  - Simultaneous reserve+write on 4 with pend=1 -> pend stays 1.
- Saturation: reserve idx 9 four times (PENDW=2) -> pend[9]=3, overflow_o=1 after the 4th. Three writes to 9 -> busy=0. A fourth write (pend=0) -> data written, no underflow.
- Stall and reset:
  - stall_i=1 while the read index changes 0->6 (regs[6]=0x55) -> value1_o holds its old value; after stall_i drops, value1_o=0x55.
  - Assert rst_i with pend[1]=2 -> next cycle all counters and outputs are 0.
